// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI-lite style arbiter: FSM states,
// master index type and the default watchdog limit.
package axi_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

endpackage

// File: rtl/axi_arb_wdog.sv
// Ownership watchdog: counts cycles the owner waits for an ask, saturates
// at TIMEOUT and raises a sticky error flag that only reset clears.
module axi_arb_wdog
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count: clear wins, otherwise count up and stop at the limit.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Count register and sticky flag, set in the same edge the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      timeout_err <= timeout_err | (cnt_nxt == LIMIT);
    end
  end

endmodule

// File: rtl/axi_arbiter.sv
// Two-master round-robin arbiter (m0 icache refill, m1 dcache) onto a
// single downstream read/write port.
//
// Handshake: a master raises rreq/wreq with address/data stable and holds
// them until it sees the matching single-cycle rask/wask; the ask is the
// acceptance of that beat. Only the owner sees asks and read data. lock
// keeps ownership across beats of a burst, including cycles with no req.
module axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 64
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (icache refill)
  input  logic            m0_rreq,
  input  logic [AW-1:0]   m0_raddr,
  output logic            m0_rask,
  output logic [AW-1:0]   m0_rdata,
  input  logic            m0_wreq,
  input  logic [AW-1:0]   m0_waddr,
  input  logic [AW-1:0]   m0_wdata,
  input  logic [AW/8-1:0] m0_wmask,
  output logic            m0_wask,
  input  logic            m0_lock,
  // master 1 (dcache)
  input  logic            m1_rreq,
  input  logic [AW-1:0]   m1_raddr,
  output logic            m1_rask,
  output logic [AW-1:0]   m1_rdata,
  input  logic            m1_wreq,
  input  logic [AW-1:0]   m1_waddr,
  input  logic [AW-1:0]   m1_wdata,
  input  logic [AW/8-1:0] m1_wmask,
  output logic            m1_wask,
  input  logic            m1_lock,
  // downstream
  output logic            AXI_RREQ,
  output logic [AW-1:0]   AXI_RADDR,
  input  logic            AXI_RASK,
  input  logic [AW-1:0]   AXI_RDATA,
  output logic            AXI_WREQ,
  output logic [AW-1:0]   AXI_WADDR,
  output logic [AW-1:0]   AXI_WDATA,
  output logic [AW/8-1:0] AXI_WMASK,
  input  logic            AXI_WASK,
  // status
  output logic [1:0]      grant,
  output logic            timeout_err,
  output logic [1:0]      dbg_state
);

  arb_state_e state;
  mst_idx_t   rr_last;

  logic            req0;
  logic            req1;
  logic            pick1;
  logic            ask_any;
  logic            own_rreq;
  logic [AW-1:0]   own_raddr;
  logic            own_wreq;
  logic [AW-1:0]   own_waddr;
  logic [AW-1:0]   own_wdata;
  logic [AW/8-1:0] own_wmask;
  logic            own_lock;
  logic            own_req;
  logic            wd_inc;
  logic            wd_clr;

  assign req0    = m0_rreq | m0_wreq;
  assign req1    = m1_rreq | m1_wreq;
  assign ask_any = AXI_RASK | AXI_WASK;
  // m1 wins only when alone or when m0 was the previous owner.
  assign pick1   = req1 & (~req0 | (rr_last == MST0));

  // Select the owner's request bundle; all zero while idle.
  always_comb begin
    own_rreq  = 1'b0;
    own_raddr = '0;
    own_wreq  = 1'b0;
    own_waddr = '0;
    own_wdata = '0;
    own_wmask = '0;
    own_lock  = 1'b0;
    if (grant[0]) begin
      own_rreq  = m0_rreq;
      own_raddr = m0_raddr;
      own_wreq  = m0_wreq;
      own_waddr = m0_waddr;
      own_wdata = m0_wdata;
      own_wmask = m0_wmask;
      own_lock  = m0_lock;
    end else if (grant[1]) begin
      own_rreq  = m1_rreq;
      own_raddr = m1_raddr;
      own_wreq  = m1_wreq;
      own_waddr = m1_waddr;
      own_wdata = m1_wdata;
      own_wmask = m1_wmask;
      own_lock  = m1_lock;
    end
  end

  assign own_req   = own_rreq | own_wreq;

  assign AXI_RREQ  = own_rreq;
  assign AXI_RADDR = own_raddr;
  assign AXI_WREQ  = own_wreq;
  assign AXI_WADDR = own_waddr;
  assign AXI_WDATA = own_wdata;
  assign AXI_WMASK = own_wmask;

  assign m0_rask   = grant[0] & AXI_RASK;
  assign m0_wask   = grant[0] & AXI_WASK;
  assign m0_rdata  = grant[0] ? AXI_RDATA : '0;
  assign m1_rask   = grant[1] & AXI_RASK;
  assign m1_wask   = grant[1] & AXI_WASK;
  assign m1_rdata  = grant[1] ? AXI_RDATA : '0;

  assign dbg_state = state;

  // Ownership FSM: arbitrate from IDLE, release on unlocked ask or dropped req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= 2'b00;
      rr_last <= MST1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick1) begin
            state   <= ST_OWN1;
            grant   <= 2'b10;
            rr_last <= MST1;
          end else if (req0) begin
            state   <= ST_OWN0;
            grant   <= 2'b01;
            rr_last <= MST0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (!own_lock && (ask_any || !own_req)) begin
            state <= ST_IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign wd_inc = (state != ST_IDLE) & own_req & ~ask_any;
  assign wd_clr = (state == ST_IDLE) | ask_any;

  axi_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .inc        (wd_inc),
    .clr        (wd_clr),
    .timeout_err(timeout_err)
  );

endmodule
